// File: rtl/muldiv_pkg.sv
// muldiv_pkg
//   Shared definitions for the iterative multiply/divide unit: operation
//   encodings, FSM state encoding, the XZR register index and the default
//   operand width. Imported by muldiv_datapath and muldiv_unit.
package muldiv_pkg;

  localparam int WIDTH_DEFAULT = 64;

  // Destination index 31 is the zero register; writes to it are dropped.
  localparam logic [4:0] XZR_IDX = 5'd31;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_RSVD = 2'b01,
    OP_UDIV = 2'b10,
    OP_SDIV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/muldiv_datapath.sv
// muldiv_datapath
//   Iteration datapath shared by multiply and divide. Holds the accumulator
//   (product or partial remainder), the A register (multiplicand, or
//   dividend shifting out while quotient bits shift in) and the B register
//   (multiplier or divisor).
// Ports:
//   Clk, ResetL       clock, asynchronous active-low reset
//   load_i            capture operands and clear the accumulator
//   step_i            perform one iteration
//   isDiv_i           1 = restoring divide step, 0 = shift-add multiply step
//   opA_i, opB_i      operands (already made unsigned by the caller)
//   nextProduct_o     accumulator value after the current step
//   nextQuotient_o    quotient value after the current step
// The next-state values are exported so the caller can capture the final
// result on the same edge as the last iteration.
module muldiv_datapath #(
  parameter int WIDTH = 64
) (
  input  logic             Clk,
  input  logic             ResetL,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             isDiv_i,
  input  logic [WIDTH-1:0] opA_i,
  input  logic [WIDTH-1:0] opB_i,
  output logic [WIDTH-1:0] nextProduct_o,
  output logic [WIDTH-1:0] nextQuotient_o
);

  logic [WIDTH-1:0] accQ, accD;
  logic [WIDTH-1:0] aQ, aD;
  logic [WIDTH-1:0] bQ, bD;
  logic [WIDTH:0]   trial;

  // Operand registers and accumulator; cleared on reset so an aborted
  // operation leaves nothing behind.
  always_ff @(posedge Clk or negedge ResetL) begin
    if (!ResetL) begin
      accQ <= '0;
      aQ   <= '0;
      bQ   <= '0;
    end else begin
      accQ <= accD;
      aQ   <= aD;
      bQ   <= bD;
    end
  end

  // One iteration per step. Divide shifts the next dividend bit into the
  // remainder and subtracts the divisor; the trial needs WIDTH+1 bits
  // because the shifted remainder can exceed WIDTH bits when the divisor
  // has its top bit set. Bit WIDTH of the trial is the borrow.
  // Multiply adds the shifted multiplicand when the current multiplier bit
  // is set; only the low WIDTH bits are kept.
  always_comb begin
    accD  = accQ;
    aD    = aQ;
    bD    = bQ;
    trial = {accQ, aQ[WIDTH-1]} - {1'b0, bQ};
    if (load_i) begin
      accD = '0;
      aD   = opA_i;
      bD   = opB_i;
    end else if (step_i) begin
      if (isDiv_i) begin
        if (!trial[WIDTH]) begin
          accD = trial[WIDTH-1:0];
        end else begin
          accD = {accQ[WIDTH-2:0], aQ[WIDTH-1]};
        end
        aD = {aQ[WIDTH-2:0], ~trial[WIDTH]};
      end else begin
        if (bQ[0]) begin
          accD = accQ + aQ;
        end
        aD = aQ << 1;
        bD = bQ >> 1;
      end
    end
  end

  assign nextProduct_o  = accD;
  assign nextQuotient_o = aD;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit
//   Iterative WIDTH-bit multiply / divide unit feeding the register file
//   write port. MUL returns the low WIDTH bits of the product, UDIV/SDIV
//   return the quotient (divide by zero returns 0). One iteration per cycle,
//   WIDTH iterations per operation.
// Ports:
//   Clk, ResetL   clock, asynchronous active-low reset
//   Start         request; accepted only when idle
//   Op            00 MUL, 01 reserved (returns 0), 10 UDIV, 11 SDIV
//   OpA, OpB      multiplicand/dividend, multiplier/divisor
//   RdIn          destination register index
//   Busy          operation in flight (RUN or DONE)
//   Done          one-cycle result-valid pulse
//   Result        result, held until replaced by the next completion
//   RdOut         destination captured at Start
//   WrEn          register write request, Done with RdOut != 31
// Configuration:
//   MULDIV_SIGNED_EN  when defined, SDIV divides signed values (truncating
//                     toward zero); otherwise Op 11 behaves as UDIV.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             Clk,
  input  logic             ResetL,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  input  logic [4:0]       RdIn,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic [4:0]       RdOut,
  output logic             WrEn
);

  localparam int              CNTW = $clog2(WIDTH);
  localparam logic [CNTW-1:0] LAST = CNTW'(WIDTH - 1);

  state_e           stateQ, stateD;
  logic [CNTW-1:0]  cntQ, cntD;
  op_e              opQ, opD;
  logic [4:0]       rdQ, rdD;
  logic             divZeroQ, divZeroD;
  logic [WIDTH-1:0] resultQ, resultD;

  logic             load, step;
  logic [WIDTH-1:0] opAIn, opBIn;
  logic [WIDTH-1:0] nextProduct, nextQuotient, quotient, finalResult;

`ifdef MULDIV_SIGNED_EN
  logic negQ, negD, negIn;

  // Signed divide runs on magnitudes; the quotient sign is remembered and
  // applied when the result is captured. The most-negative magnitude is
  // representable as an unsigned value, so /-1 wraps back to itself.
  always_comb begin
    opAIn = OpA;
    opBIn = OpB;
    negIn = 1'b0;
    if (Op == OP_SDIV) begin
      opAIn = OpA[WIDTH-1] ? -OpA : OpA;
      opBIn = OpB[WIDTH-1] ? -OpB : OpB;
      negIn = OpA[WIDTH-1] ^ OpB[WIDTH-1];
    end
  end

  // Sign of the pending quotient, captured with the operands.
  always_ff @(posedge Clk or negedge ResetL) begin
    if (!ResetL) begin
      negQ <= 1'b0;
    end else begin
      negQ <= negD;
    end
  end

  assign negD     = load ? negIn : negQ;
  assign quotient = negQ ? -nextQuotient : nextQuotient;
`else
  assign opAIn    = OpA;
  assign opBIn    = OpB;
  assign quotient = nextQuotient;
`endif

  muldiv_datapath #(.WIDTH(WIDTH)) datapath (
    .Clk            (Clk),
    .ResetL         (ResetL),
    .load_i         (load),
    .step_i         (step),
    .isDiv_i        (opQ[1]),
    .opA_i          (opAIn),
    .opB_i          (opBIn),
    .nextProduct_o  (nextProduct),
    .nextQuotient_o (nextQuotient)
  );

  // Result chosen from the datapath's post-step values so it lands in the
  // result register on the same edge as the final iteration.
  always_comb begin
    finalResult = quotient;
    case (opQ)
      OP_MUL:  finalResult = nextProduct;
      OP_RSVD: finalResult = '0;
      default: finalResult = quotient;
    endcase
  end

  // Control state, iteration counter and captured request fields.
  always_ff @(posedge Clk or negedge ResetL) begin
    if (!ResetL) begin
      stateQ   <= IDLE;
      cntQ     <= '0;
      opQ      <= OP_MUL;
      rdQ      <= '0;
      divZeroQ <= 1'b0;
      resultQ  <= '0;
    end else begin
      stateQ   <= stateD;
      cntQ     <= cntD;
      opQ      <= opD;
      rdQ      <= rdD;
      divZeroQ <= divZeroD;
      resultQ  <= resultD;
    end
  end

  // FSM: IDLE accepts a request, RUN iterates WIDTH times, DONE presents
  // the result for one cycle. A divide by zero spends a single RUN cycle
  // without stepping the datapath and completes with a zero result.
  always_comb begin
    stateD   = stateQ;
    cntD     = cntQ;
    opD      = opQ;
    rdD      = rdQ;
    divZeroD = divZeroQ;
    resultD  = resultQ;
    load     = 1'b0;
    step     = 1'b0;
    case (stateQ)
      IDLE: begin
        if (Start) begin
          opD      = op_e'(Op);
          rdD      = RdIn;
          cntD     = '0;
          divZeroD = Op[1] && (OpB == '0);
          load     = 1'b1;
          stateD   = RUN;
        end
      end
      RUN: begin
        if (divZeroQ) begin
          resultD = '0;
          stateD  = DONE;
        end else begin
          step = 1'b1;
          cntD = cntQ + CNTW'(1);
          if (cntQ == LAST) begin
            resultD = finalResult;
            stateD  = DONE;
          end
        end
      end
      DONE: begin
        stateD = IDLE;
      end
      default: begin
        stateD = IDLE;
      end
    endcase
  end

  assign Busy   = (stateQ != IDLE);
  assign Done   = (stateQ == DONE);
  assign Result = resultQ;
  assign RdOut  = rdQ;
  assign WrEn   = (stateQ == DONE) && (rdQ != XZR_IDX);

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit
//   Directed self-checking bench for muldiv_unit (WIDTH = 64). Expected
//   values are written out by hand; SDIV expectations follow whether
//   MULDIV_SIGNED_EN is defined for the build.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        Clk;
  logic        ResetL;
  logic        Start;
  logic [1:0]  Op;
  logic [63:0] OpA;
  logic [63:0] OpB;
  logic [4:0]  RdIn;
  logic        Busy;
  logic        Done;
  logic [63:0] Result;
  logic [4:0]  RdOut;
  logic        WrEn;

  int compared;
  int mismatched;

  muldiv_unit #(.WIDTH(64)) dut (
    .Clk    (Clk),
    .ResetL (ResetL),
    .Start  (Start),
    .Op     (Op),
    .OpA    (OpA),
    .OpB    (OpB),
    .RdIn   (RdIn),
    .Busy   (Busy),
    .Done   (Done),
    .Result (Result),
    .RdOut  (RdOut),
    .WrEn   (WrEn)
  );

  // 10 ns clock.
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Single comparison point: counts it and reports a failure.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Presents a request at the falling edge, holds it across one rising edge
  // and returns 1 ns after that edge with Start dropped.
  task automatic applyStimulus(input logic [1:0] op, input logic [63:0] a,
                               input logic [63:0] b, input logic [4:0] rd);
    @(negedge Clk);
    Start = 1'b1;
    Op    = op;
    OpA   = a;
    OpB   = b;
    RdIn  = rd;
    @(posedge Clk);
    #1;
    Start = 1'b0;
  endtask

  // Counts rising edges until Done is seen; -1 if the budget runs out.
  task automatic waitDone(input int budget, output int cycles);
    cycles = -1;
    for (int c = 1; c <= budget; c++) begin
      @(posedge Clk);
      #1;
      if (Done) begin
        cycles = c;
        break;
      end
    end
  endtask

  // Full operation: issue, check latency and DONE-cycle outputs, then check
  // that the pulse lasts one cycle and the result is held.
  task automatic runOp(input string tag, input logic [1:0] op,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] rd, input int expLat,
                       input logic [63:0] expRes, input logic expWr);
    int lat;
    applyStimulus(op, a, b, rd);
    checkOutput({tag, " busy"}, {63'd0, Busy}, 64'd1);
    waitDone(200, lat);
    checkOutput({tag, " latency"}, 64'(lat), 64'(expLat));
    checkOutput({tag, " result"}, Result, expRes);
    checkOutput({tag, " rdout"}, {59'd0, RdOut}, {59'd0, rd});
    checkOutput({tag, " wren"}, {63'd0, WrEn}, {63'd0, expWr});
    @(posedge Clk);
    #1;
    checkOutput({tag, " done drop"}, {63'd0, Done}, 64'd0);
    checkOutput({tag, " wren drop"}, {63'd0, WrEn}, 64'd0);
    checkOutput({tag, " idle"}, {63'd0, Busy}, 64'd0);
    checkOutput({tag, " held"}, Result, expRes);
  endtask

  initial begin
    int doneCount;
    int doneCycle;
    compared   = 0;
    mismatched = 0;
    Start      = 1'b0;
    Op         = 2'b00;
    OpA        = '0;
    OpB        = '0;
    RdIn       = '0;
    ResetL     = 1'b1;

    // Reset state
    #2 ResetL = 1'b0;
    #10;
    checkOutput("reset busy", {63'd0, Busy}, 64'd0);
    checkOutput("reset done", {63'd0, Done}, 64'd0);
    checkOutput("reset wren", {63'd0, WrEn}, 64'd0);
    checkOutput("reset result", Result, 64'd0);
    checkOutput("reset rdout", {59'd0, RdOut}, 64'd0);
    @(negedge Clk);
    ResetL = 1'b1;
    $display("[TB] reset released");

    // Multiply
    runOp("mul 7*6", OP_MUL, 64'd7, 64'd6, 5'd3, 64, 64'd42, 1'b1);
    runOp("mul overflow", OP_MUL, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 5'd2, 64,
          64'hFFFF_FFFF_FFFF_FFFD, 1'b1);

    // Unsigned divide, including a divisor with its top bit set
    runOp("udiv 100/7", OP_UDIV, 64'd100, 64'd7, 5'd5, 64, 64'd14, 1'b1);
    runOp("udiv big", OP_UDIV, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001,
          5'd1, 64, 64'd1, 1'b1);
    runOp("udiv by 0", OP_UDIV, 64'd1234, 64'd0, 5'd6, 1, 64'd0, 1'b1);

    // Signed divide
`ifdef MULDIV_SIGNED_EN
    runOp("sdiv -100/7", OP_SDIV, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd8, 64,
          64'hFFFF_FFFF_FFFF_FFF2, 1'b1);
    runOp("sdiv min/-1", OP_SDIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
          5'd8, 64, 64'h8000_0000_0000_0000, 1'b1);
    runOp("sdiv -100/-7", OP_SDIV, 64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9,
          5'd8, 64, 64'd14, 1'b1);
`else
    runOp("sdiv -100/7", OP_SDIV, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd8, 64,
          64'd2635249153387078788, 1'b1);
    runOp("sdiv min/-1", OP_SDIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
          5'd8, 64, 64'd0, 1'b1);
    runOp("sdiv -100/-7", OP_SDIV, 64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9,
          5'd8, 64, 64'd0, 1'b1);
`endif
    runOp("sdiv by 0", OP_SDIV, 64'hFFFF_FFFF_FFFF_FF9C, 64'd0, 5'd9, 1, 64'd0, 1'b1);

    // Reserved op: multiply timing, zero result
    runOp("rsvd", OP_RSVD, 64'd7, 64'd6, 5'd10, 64, 64'd0, 1'b1);

    // Start pulses at cycles 10 and 30 of a running MUL are ignored
    applyStimulus(OP_MUL, 64'd9, 64'd8, 5'd4);
    doneCount = 0;
    doneCycle = -1;
    for (int c = 1; c <= 80; c++) begin
      @(negedge Clk);
      Start = (c == 10) || (c == 30);
      Op    = OP_MUL;
      OpA   = 64'd2;
      OpB   = 64'd2;
      RdIn  = 5'd7;
      @(posedge Clk);
      #1;
      if (Done) begin
        doneCount++;
        if (doneCycle < 0) begin
          doneCycle = c;
          checkOutput("ignore result", Result, 64'd72);
          checkOutput("ignore rdout", {59'd0, RdOut}, 64'd4);
        end
      end
    end
    Start = 1'b0;
    checkOutput("ignore done count", 64'(doneCount), 64'd1);
    checkOutput("ignore latency", 64'(doneCycle), 64'd64);

    // XZR destination suppresses the write request
    runOp("mul xzr", OP_MUL, 64'd5, 64'd5, 5'd31, 64, 64'd25, 1'b0);

    // Asynchronous reset in the middle of a divide
    applyStimulus(OP_UDIV, 64'd1000, 64'd3, 5'd12);
    repeat (19) @(posedge Clk);
    #2 ResetL = 1'b0;
    #1;
    checkOutput("abort busy", {63'd0, Busy}, 64'd0);
    checkOutput("abort done", {63'd0, Done}, 64'd0);
    checkOutput("abort wren", {63'd0, WrEn}, 64'd0);
    checkOutput("abort result", Result, 64'd0);
    checkOutput("abort rdout", {59'd0, RdOut}, 64'd0);
    @(negedge Clk);
    ResetL = 1'b1;
    doneCount = 0;
    for (int c = 0; c < 70; c++) begin
      @(posedge Clk);
      #1;
      if (Done || WrEn) doneCount++;
    end
    checkOutput("abort no write", 64'(doneCount), 64'd0);
    runOp("mul after reset", OP_MUL, 64'd3, 64'd4, 5'd11, 64, 64'd12, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
